// File: rtl/jedro_1_pkg.sv
// ---------------------------------------------------------------------------
// jedro_1_pkg
// Shared constants for the jedro_1 writeback path: register file geometry and
// writeback requester indices used by jedro_1_wb_arbiter and its sub-modules.
// No ports (package).
// ---------------------------------------------------------------------------
package jedro_1_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = $clog2(DATA_WIDTH);
    localparam int NUM_REGISTERS  = 2 ** REG_ADDR_WIDTH;

    // Writeback requester indices into the req_* vectors.
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
endpackage

// File: rtl/jedro_1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// jedro_1_rr_arbiter
// Round-robin arbiter: grants the first valid requester at or after the
// internal pointer (modulo NUM_REQ). The pointer moves to granted+1 only when
// the caller signals that the grant was consumed.
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset (pointer back to the ALU slot)
//   valid    per-requester request vector
//   advance  grant consumed this cycle, move the pointer
//   grant    one-hot grant (all zero when nothing is valid)
// ---------------------------------------------------------------------------
module jedro_1_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    import jedro_1_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   next_hi;
    logic [PTR_W-1:0]   next_lo;
    logic [NUM_REQ-1:0] grant_hi;
    logic [NUM_REQ-1:0] grant_lo;
    logic               found_hi;

    function automatic logic [PTR_W-1:0] after(input int k);
        return (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
    endfunction

    // Two priority windows: requesters at/after the pointer win over those
    // before it. Scanning downward leaves the lowest index in each window.
    always_comb begin
        grant_hi = '0;
        grant_lo = '0;
        next_hi  = rr_ptr;
        next_lo  = rr_ptr;
        found_hi = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[k]) begin
                if (k >= int'(rr_ptr)) begin
                    grant_hi    = '0;
                    grant_hi[k] = 1'b1;
                    next_hi     = after(k);
                    found_hi    = 1'b1;
                end else begin
                    grant_lo    = '0;
                    grant_lo[k] = 1'b1;
                    next_lo     = after(k);
                end
            end
        end
        grant    = found_hi ? grant_hi : grant_lo;
        next_ptr = found_hi ? next_hi  : next_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= PTR_W'(WB_SRC_ALU);
        end else if (advance) begin
            rr_ptr <= next_ptr;
        end
    end
endmodule

// File: rtl/jedro_1_wb_arbiter.sv
// ---------------------------------------------------------------------------
// jedro_1_wb_arbiter
// Shares register file write port C between NUM_REQ writeback requesters
// (0 = ALU, 1 = LSU) with round-robin arbitration, keeps a per-register
// pending scoreboard (set at issue, cleared at writeback) and flags RAW
// hazards on read ports A/B to decode.
// Optional feature macro: JEDRO_1_WB_FWD_EN -- forward the registered write
// port C value to decode, removing the hazard one cycle earlier.
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   iss_valid_i/iss_addr_i         issue with destination register
//   iss_ready_o                    issue accepted (no WAW on destination)
//   req_valid_i/req_addr_i/req_data_i  flattened writeback requests
//   req_ready_o                    one-hot grant (transfer = valid & ready)
//   wpc_addr_o/wpc_data_o/wpc_we_o registered regfile write port C
//   rpa_addr_i/rpb_addr_i          decode read addresses
//   hazard_a_o/hazard_b_o          operand not yet available, stall
//   fwd_a_o/fwd_b_o, fwd_*_sel_o   forwarded operands and their selects
// ---------------------------------------------------------------------------
module jedro_1_wb_arbiter #(
    parameter int DATA_WIDTH     = jedro_1_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = $clog2(DATA_WIDTH),
    parameter int NUM_REQ        = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              iss_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]         iss_addr_i,
    output logic                              iss_ready_o,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [REG_ADDR_WIDTH-1:0]         wpc_addr_o,
    output logic [DATA_WIDTH-1:0]             wpc_data_o,
    output logic                              wpc_we_o,
    input  logic [REG_ADDR_WIDTH-1:0]         rpa_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0]         rpb_addr_i,
    output logic                              hazard_a_o,
    output logic                              hazard_b_o,
    output logic [DATA_WIDTH-1:0]             fwd_a_o,
    output logic [DATA_WIDTH-1:0]             fwd_b_o,
    output logic                              fwd_a_sel_o,
    output logic                              fwd_b_sel_o
);
    import jedro_1_pkg::*;

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [NUM_REQ-1:0]        grant;
    logic                      transfer;
    logic [REG_ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic [NUM_REGS-1:0]       pending;
    logic                      issue_fire;

    jedro_1_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk_i),
        .rst     (rst_i),
        .valid   (req_valid_i),
        .advance (transfer),
        .grant   (grant)
    );

    // The output stage never stalls, so any grant is a transfer.
    assign req_ready_o = rst_i ? '0 : grant;
    assign transfer    = |req_ready_o;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_addr = sel_addr | req_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                sel_data = sel_data | req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Writes to x0 are consumed but never enable the regfile.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wpc_we_o   <= 1'b0;
            wpc_addr_o <= '0;
            wpc_data_o <= '0;
        end else begin
            wpc_we_o <= transfer && (sel_addr != '0);
            if (transfer) begin
                wpc_addr_o <= sel_addr;
                wpc_data_o <= sel_data;
            end
        end
    end

    assign iss_ready_o = !((iss_addr_i != '0) && pending[iss_addr_i]);
    assign issue_fire  = iss_valid_i && iss_ready_o;

    // Set has priority over clear so a same-edge re-issue keeps the entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending <= '0;
        end else begin
            pending[0] <= 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue_fire && (iss_addr_i == REG_ADDR_WIDTH'(r))) begin
                    pending[r] <= 1'b1;
                end else if (wpc_we_o && (wpc_addr_o == REG_ADDR_WIDTH'(r))) begin
                    pending[r] <= 1'b0;
                end
            end
        end
    end

`ifdef JEDRO_1_WB_FWD_EN
    logic hit_a;
    logic hit_b;

    assign hit_a       = wpc_we_o && (wpc_addr_o == rpa_addr_i) && (rpa_addr_i != '0);
    assign hit_b       = wpc_we_o && (wpc_addr_o == rpb_addr_i) && (rpb_addr_i != '0);
    assign fwd_a_sel_o = hit_a;
    assign fwd_b_sel_o = hit_b;
    assign fwd_a_o     = hit_a ? wpc_data_o : '0;
    assign fwd_b_o     = hit_b ? wpc_data_o : '0;
    assign hazard_a_o  = hit_a ? 1'b0 : pending[rpa_addr_i];
    assign hazard_b_o  = hit_b ? 1'b0 : pending[rpb_addr_i];
`else
    assign fwd_a_sel_o = 1'b0;
    assign fwd_b_sel_o = 1'b0;
    assign fwd_a_o     = '0;
    assign fwd_b_o     = '0;
    assign hazard_a_o  = pending[rpa_addr_i];
    assign hazard_b_o  = pending[rpb_addr_i];
`endif
endmodule

// File: tb/tb_jedro_1_wb_arbiter.sv
module tb_jedro_1_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk;
    logic          rst;
    logic          iss_valid;
    logic [AW-1:0] iss_addr;
    logic          iss_ready;
    logic [NR-1:0] req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic [AW-1:0] wpc_addr;
    logic [DW-1:0] wpc_data;
    logic          wpc_we;
    logic [AW-1:0] rpa_addr;
    logic [AW-1:0] rpb_addr;
    logic          hazard_a;
    logic          hazard_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic          fwd_a_sel;
    logic          fwd_b_sel;

    jedro_1_wb_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .iss_ready_o (iss_ready),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .wpc_addr_o  (wpc_addr),
        .wpc_data_o  (wpc_data),
        .wpc_we_o    (wpc_we),
        .rpa_addr_i  (rpa_addr),
        .rpb_addr_i  (rpb_addr),
        .hazard_a_o  (hazard_a),
        .hazard_b_o  (hazard_b),
        .fwd_a_o     (fwd_a),
        .fwd_b_o     (fwd_b),
        .fwd_a_sel_o (fwd_a_sel),
        .fwd_b_sel_o (fwd_b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[k]         = 1'b1;
        req_addr[k*AW +: AW] = a;
        req_data[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_req();
        iss_valid = 1'b0;
        iss_addr  = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    valid;
        logic [1:0]    grant;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rr_vec_t;

    rr_vec_t tbl[8];

    // Reference model state for the random phase.
    bit            pend[32];
    int            mptr;
    bit            m_xfer;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            hv[NR];
    logic [AW-1:0] ha[NR];
    logic [DW-1:0] hd[NR];
    int            waitc[NR];

    task automatic chk_port(input string tag, input logic [AW-1:0] rp, input logic hz,
                            input logic sel, input logic [DW-1:0] fd);
        logic          e_hz;
        logic          e_sel;
        logic [DW-1:0] e_fd;
        e_hz  = pend[rp];
        e_sel = 1'b0;
        e_fd  = '0;
`ifdef JEDRO_1_WB_FWD_EN
        if (m_we && m_addr == rp && rp != 0) begin
            e_hz  = 1'b0;
            e_sel = 1'b1;
            e_fd  = m_data;
        end
`endif
        chk({tag, "_hazard"}, hz, e_hz);
        chk({tag, "_sel"}, sel, e_sel);
        chk({tag, "_fwd"}, fd, e_fd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        iss_valid = 1'b0;
        iss_addr  = '0;
        rpa_addr  = '0;
        rpb_addr  = '0;
        idle_req();

        // Round-robin table: ALU always x5, LSU always x6.
        tbl[0] = '{2'b11, 2'b01, 1'b0, 5'd0, 32'h0};
        tbl[1] = '{2'b11, 2'b10, 1'b1, 5'd5, 32'hA000_0005};
        tbl[2] = '{2'b11, 2'b01, 1'b1, 5'd6, 32'hB000_0006};
        tbl[3] = '{2'b01, 2'b01, 1'b1, 5'd5, 32'hA000_0005};
        tbl[4] = '{2'b10, 2'b10, 1'b1, 5'd5, 32'hA000_0005};
        tbl[5] = '{2'b00, 2'b00, 1'b1, 5'd6, 32'hB000_0006};
        tbl[6] = '{2'b10, 2'b10, 1'b0, 5'd0, 32'h0};
        tbl[7] = '{2'b11, 2'b01, 1'b1, 5'd6, 32'hB000_0006};

        do_reset();
        chk("rst_we", wpc_we, 0);
        chk("rst_addr", wpc_addr, 0);
        chk("rst_data", wpc_data, 0);
        for (int i = 0; i < 8; i++) begin
            set_req(0, 5'd5, 32'hA000_0005);
            set_req(1, 5'd6, 32'hB000_0006);
            req_valid = tbl[i].valid;
            #2;
            chk($sformatf("rr_grant%0d", i), req_ready, tbl[i].grant);
            chk($sformatf("rr_we%0d", i), wpc_we, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("rr_addr%0d", i), wpc_addr, tbl[i].addr);
                chk($sformatf("rr_data%0d", i), wpc_data, tbl[i].data);
            end
            step();
        end

        // Asynchronous reset mid-cycle with a write in flight and x3 pending.
        idle_req();
        iss_valid = 1'b1;
        iss_addr  = 5'd3;
        set_req(0, 5'd5, 32'hA000_0005);
        step();
        iss_valid = 1'b0;
        rpa_addr  = 5'd3;
        #2;
        chk("pre_rst_hazard", hazard_a, 1);
        chk("pre_rst_we", wpc_we, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_we", wpc_we, 0);
        chk("async_rst_addr", wpc_addr, 0);
        chk("async_rst_data", wpc_data, 0);
        chk("async_rst_ready", req_ready, 0);
        chk("async_rst_hazard", hazard_a, 0);
        idle_req();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        iss_addr = 5'd3;
        #2;
        chk("post_rst_hazard", hazard_a, 0);
        chk("post_rst_iss_ready", iss_ready, 1);

        // Write to x0: consumed, no regfile write.
        set_req(0, 5'd0, 32'hDEAD_BEEF);
        #2;
        chk("x0_grant", req_ready, 2'b01);
        step();
        idle_req();
        iss_addr = 5'd5;
        #2;
        chk("x0_we", wpc_we, 0);
        chk("x0_addr", wpc_addr, 0);
        chk("x0_data", wpc_data, 32'hDEAD_BEEF);
        chk("x0_iss_ready", iss_ready, 1);
        step();

        // RAW on x7, resolved by an LSU writeback.
        iss_valid = 1'b1;
        iss_addr  = 5'd7;
        #2;
        chk("raw_iss_ready", iss_ready, 1);
        step();
        iss_valid = 1'b0;
        rpa_addr  = 5'd7;
        #2;
        chk("raw_hazard0", hazard_a, 1);
        step();
        #1;
        chk("raw_hazard1", hazard_a, 1);
        set_req(1, 5'd7, 32'h0000_1234);
        #1;
        chk("raw_grant", req_ready, 2'b10);
        step();
        idle_req();
        #2;
        chk("raw_we", wpc_we, 1);
        chk("raw_addr", wpc_addr, 7);
`ifdef JEDRO_1_WB_FWD_EN
        chk("raw_fwd_hazard", hazard_a, 0);
        chk("raw_fwd_sel", fwd_a_sel, 1);
        chk("raw_fwd_data", fwd_a, 32'h0000_1234);
`else
        chk("raw_nofwd_hazard", hazard_a, 1);
        chk("raw_nofwd_sel", fwd_a_sel, 0);
        chk("raw_nofwd_data", fwd_a, 0);
`endif
        step();
        #1;
        chk("raw_hazard_clear", hazard_a, 0);
        chk("raw_sel_clear", fwd_a_sel, 0);

        // WAW on x9, then a same-edge writeback and re-issue of x9.
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        step();
        rpb_addr = 5'd9;
        #2;
        chk("waw_iss_ready", iss_ready, 0);
        chk("waw_hazard_b", hazard_b, 1);
        iss_valid = 1'b0;
        set_req(0, 5'd9, 32'h0000_0099);
        step();
        idle_req();
        step();
        #1;
        chk("waw_cleared_hazard", hazard_b, 0);
        chk("waw_cleared_ready", iss_ready, 1);
        set_req(1, 5'd9, 32'h0000_0055);
        step();
        idle_req();
        iss_valid = 1'b1;
        #2;
        chk("same_edge_we", wpc_we, 1);
        chk("same_edge_iss_ready", iss_ready, 1);
        step();
        iss_valid = 1'b0;
        #2;
        chk("same_edge_pending", hazard_b, 1);
        chk("same_edge_iss_block", iss_ready, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
        mptr = 0; m_xfer = 0; m_we = 0; m_addr = '0; m_data = '0;
        for (int k = 0; k < NR; k++) begin
            hv[k] = 0; ha[k] = '0; hd[k] = '0; waitc[k] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int            g;
            int            best;
            logic [NR-1:0] eg;
            logic          e_iss;
            for (int k = 0; k < NR; k++) begin
                if (!hv[k]) begin
                    hv[k] = ($urandom_range(0, 99) < 60);
                    ha[k] = AW'($urandom_range(0, 15));
                    hd[k] = $urandom;
                end
                req_valid[k]         = hv[k];
                req_addr[k*AW +: AW] = ha[k];
                req_data[k*DW +: DW] = hd[k];
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_addr  = AW'($urandom_range(0, 15));
            rpa_addr  = AW'($urandom_range(0, 15));
            rpb_addr  = AW'($urandom_range(0, 15));
            #2;
            g = -1;
            best = NR;
            for (int k = 0; k < NR; k++) begin
                if (hv[k] && ((k - mptr + NR) % NR) < best) begin
                    best = (k - mptr + NR) % NR;
                    g = k;
                end
            end
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            chk("rand_grant", req_ready, eg);
            chk("rand_we", wpc_we, m_we);
            if (m_xfer) begin
                chk("rand_addr", wpc_addr, m_addr);
                chk("rand_data", wpc_data, m_data);
            end
            e_iss = !(iss_addr != 0 && pend[iss_addr]);
            chk("rand_iss_ready", iss_ready, e_iss);
            chk_port("rand_a", rpa_addr, hazard_a, fwd_a_sel, fwd_a);
            chk_port("rand_b", rpb_addr, hazard_b, fwd_b_sel, fwd_b);
            for (int k = 0; k < NR; k++) begin
                if (k == g) begin
                    chk("rand_fair_wait", waitc[k] < NR, 1);
                    waitc[k] = 0;
                end else if (hv[k]) begin
                    waitc[k]++;
                end
            end
            // Model update for the coming edge: clear first, set overrides.
            if (m_we) pend[m_addr] = 1'b0;
            if (iss_valid && e_iss && iss_addr != 0) pend[iss_addr] = 1'b1;
            m_xfer = (g >= 0);
            if (g >= 0) begin
                m_addr = ha[g];
                m_data = hd[g];
                m_we   = (ha[g] != 0);
                mptr   = (g + 1) % NR;
                hv[g]  = 0;
            end else begin
                m_we = 0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
